// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR filter (fir_serial_mac).
// Holds the FSM state type, width helpers and the number-format helpers
// used by both the top level and the tap register file.
// The helpers work on 64-bit containers, so BITSIZE is limited to values
// that keep 2*BITSIZE + clog2(LENGTH) within 64 bits.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2
    } fir_state_e;

    // Number of address bits needed to index n entries (minimum 1).
    function automatic int clog2(input int n);
        int r;
        r = 32'sd0;
        for (int v = n - 32'sd1; v > 32'sd0; v = v >>> 1) begin
            r = r + 32'sd1;
        end
        if (r == 32'sd0) begin
            r = 32'sd1;
        end else begin
            r = r;
        end
        return r;
    endfunction

    // Accumulator width: full product plus guard bits for LENGTH additions.
    function automatic int acc_width(input int bits, input int len);
        return (32'sd2 * bits) + clog2(len);
    endfunction

    // Offset-binary to two's complement: flipping the MSB of a w-bit value.
    function automatic logic [63:0] offset_to_signed(input logic [63:0] v, input int w);
        return v ^ (64'd1 << (w - 32'sd1));
    endfunction

    // Two's complement to offset-binary; the same MSB flip in reverse.
    function automatic logic [63:0] signed_to_offset(input logic [63:0] v, input int w);
        return v ^ (64'd1 << (w - 32'sd1));
    endfunction

    // Clamp a signed value to the signed range of a w-bit word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 32'sd1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 32'sd1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/fir_tap_ram.sv
// DEPTH x WIDTH register file with one synchronous write port and one
// combinational read port. Used for both the sample ring buffer and the
// coefficient table. Writes to addresses >= DEPTH are dropped and reads
// from such addresses return zero.
module fir_tap_ram
    import fir_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      we_i,
    input  logic [clog2(DEPTH)-1:0]   waddr_i,
    input  logic [WIDTH-1:0]          wdata_i,
    input  logic [clog2(DEPTH)-1:0]   raddr_i,
    output logic [WIDTH-1:0]          rdata_o
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_ok_s;
    logic             rd_ok_s;

    assign wr_ok_s = ({1'b0, waddr_i} < DEPTH_EXT);
    assign rd_ok_s = ({1'b0, raddr_i} < DEPTH_EXT);

    // Storage: cleared to zero on reset, written one entry per cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (we_i && wr_ok_s) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: out-of-range indices read as zero instead of X.
    always_comb begin
        rdata_o = {WIDTH{1'b0}};
        if (rd_ok_s) begin
            rdata_o = mem_q[raddr_i];
        end else begin
            rdata_o = {WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR filter built around one multiply-accumulate unit.
// A rising edge on START_FLAG captures DATA_IN into a circular sample
// buffer; the MAC then walks all LENGTH taps (one per clock), rounds,
// saturates and presents the offset-binary result on DATA_OUT with a
// single-cycle DATA_VALID pulse, LENGTH+2 cycles after the strobe edge.
// Optional build macro FIR_OVERRUN_DET_EN adds a sticky OVERRUN output
// that flags strobes dropped because the block was busy or disabled.
module fir_serial_mac
    import fir_pkg::*;
#(
    parameter int BITSIZE = 16,
    parameter int LENGTH  = 10
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      EN,
    input  logic                      START_FLAG,
    input  logic [BITSIZE-1:0]        DATA_IN,
    input  logic                      COEFF_WE,
    input  logic [clog2(LENGTH)-1:0]  COEFF_ADDR,
    input  logic [BITSIZE-1:0]        COEFF_DIN,
    output logic [BITSIZE-1:0]        DATA_OUT,
    output logic                      DATA_VALID
`ifdef FIR_OVERRUN_DET_EN
    ,
    output logic                      OVERRUN
`endif
);

    localparam int AW    = clog2(LENGTH);
    localparam int ACC_W = acc_width(BITSIZE, LENGTH);
    localparam int PW    = 2 * BITSIZE;

    localparam logic [AW-1:0]           LAST_TAP = AW'(LENGTH - 1);
    localparam logic [AW:0]             LEN_EXT  = (AW + 1)'(LENGTH);
    localparam logic [BITSIZE-1:0]      MIDSCALE = {1'b1, {(BITSIZE - 1){1'b0}}};
    // Half an output LSB, added before the arithmetic shift for round-half-up.
    localparam logic signed [ACC_W-1:0] RND_C    = ACC_W'(64'sd1 <<< (BITSIZE - 2));

    // State registers and their next-state values.
    fir_state_e               state_q, state_d;
    logic                     start_q;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            tap_q, tap_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [BITSIZE-1:0]       dout_q, dout_d;
    logic                     valid_q, valid_d;

    // Datapath signals.
    logic                     event_s;
    logic                     smp_we_s;
    logic                     coef_we_s;
    logic [BITSIZE-1:0]       din_signed_s;
    logic [AW-1:0]            rd_addr_s;
    logic [AW:0]              rd_calc_s;
    logic [BITSIZE-1:0]       smp_rd_s;
    logic [BITSIZE-1:0]       coef_rd_s;
    logic signed [PW-1:0]     prod_s;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic signed [ACC_W-1:0]  acc_rnd_s;
    logic signed [ACC_W-1:0]  y_s;
    logic signed [63:0]       y_wide_s;
    logic signed [63:0]       y_sat_s;
    logic [BITSIZE-1:0]       result_s;

    // Strobe edge: only the first cycle of a (possibly long) high pulse counts.
    assign event_s = START_FLAG & ~start_q;

    // Incoming sample converted to two's complement for storage.
    assign din_signed_s = BITSIZE'(offset_to_signed(64'(DATA_IN), BITSIZE));

    // Coefficients may only change while no MAC sequence is running.
    assign coef_we_s = COEFF_WE && (state_q == IDLE);

    // Tap read address: x[n-k] lives at (wr_ptr - k) mod LENGTH.
    always_comb begin
        rd_calc_s = {(AW + 1){1'b0}};
        if ({1'b0, tap_q} <= {1'b0, wr_ptr_q}) begin
            rd_calc_s = {1'b0, wr_ptr_q} - {1'b0, tap_q};
        end else begin
            rd_calc_s = {1'b0, wr_ptr_q} + LEN_EXT - {1'b0, tap_q};
        end
        rd_addr_s = rd_calc_s[AW-1:0];
    end

    fir_tap_ram #(
        .WIDTH (BITSIZE),
        .DEPTH (LENGTH)
    ) u_sample_ram (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .we_i    (smp_we_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (din_signed_s),
        .raddr_i (rd_addr_s),
        .rdata_o (smp_rd_s)
    );

    fir_tap_ram #(
        .WIDTH (BITSIZE),
        .DEPTH (LENGTH)
    ) u_coeff_ram (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .we_i    (coef_we_s),
        .waddr_i (COEFF_ADDR),
        .wdata_i (COEFF_DIN),
        .raddr_i (tap_q),
        .rdata_o (coef_rd_s)
    );

    // Single signed multiplier; operands sign-extended so the product is exact.
    assign prod_s     = PW'($signed(coef_rd_s)) * PW'($signed(smp_rd_s));
    assign prod_ext_s = ACC_W'(prod_s);

    // Output stage: round, shift back to Q1.(BITSIZE-1), clamp, re-offset.
    assign acc_rnd_s = acc_q + RND_C;
    assign y_s       = acc_rnd_s >>> (BITSIZE - 1);
    assign y_wide_s  = 64'(y_s);
    assign y_sat_s   = saturate(y_wide_s, BITSIZE);
    assign result_s  = BITSIZE'(signed_to_offset(y_sat_s, BITSIZE));

    // Sequencer: capture in IDLE, one tap per cycle in MAC, publish in ROUND.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        tap_d    = tap_q;
        acc_d    = acc_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;
        smp_we_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (EN && event_s) begin
                    smp_we_s = 1'b1;
                    acc_d    = {ACC_W{1'b0}};
                    tap_d    = {AW{1'b0}};
                    state_d  = MAC;
                end else begin
                    state_d  = IDLE;
                end
            end
            MAC: begin
                if (!EN) begin
                    // Abort: the stored sample stays but wr_ptr does not move,
                    // so the next accepted sample overwrites it.
                    state_d = IDLE;
                end else begin
                    acc_d = acc_q + prod_ext_s;
                    if (tap_q == LAST_TAP) begin
                        state_d = ROUND;
                    end else begin
                        tap_d = tap_q + {{(AW - 1){1'b0}}, 1'b1};
                    end
                end
            end
            ROUND: begin
                if (!EN) begin
                    state_d = IDLE;
                end else begin
                    dout_d  = result_s;
                    valid_d = 1'b1;
                    if (wr_ptr_q == LAST_TAP) begin
                        wr_ptr_d = {AW{1'b0}};
                    end else begin
                        wr_ptr_d = wr_ptr_q + {{(AW - 1){1'b0}}, 1'b1};
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer, accumulator and output registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            wr_ptr_q <= {AW{1'b0}};
            tap_q    <= {AW{1'b0}};
            acc_q    <= {ACC_W{1'b0}};
            dout_q   <= MIDSCALE;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= START_FLAG;
            wr_ptr_q <= wr_ptr_d;
            tap_q    <= tap_d;
            acc_q    <= acc_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
        end
    end

    assign DATA_OUT   = dout_q;
    assign DATA_VALID = valid_q;

`ifdef FIR_OVERRUN_DET_EN
    logic en_q;
    logic overrun_q, overrun_d;

    // Overrun flag: set by any dropped strobe, cleared when EN rises.
    always_comb begin
        overrun_d = overrun_q;
        if (event_s && ((state_q != IDLE) || !EN)) begin
            overrun_d = 1'b1;
        end else if (EN && !en_q) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // EN history for edge detection and the sticky overrun register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            en_q      <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            en_q      <= EN;
            overrun_q <= overrun_d;
        end
    end

    assign OVERRUN = overrun_q;
`endif

endmodule
